// File: rtl/flag_branch_unit_if.sv
// Flag/branch bus between the EX-stage ALU/branch logic and the flag branch unit.
// slave is the unit's view; master is the driver's view (EX stage or bench).
interface flag_branch_unit_if #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic             alu_valid;
    logic [2:0]       flag_we;
    logic             carry_in;
    logic             negative_in;
    logic             zero_in;
    logic             set_c;
    logic             clr_c;
    logic             br_valid;
    logic [1:0]       br_cond;
    logic [WIDTH-1:0] br_target;
    logic             int_save;
    logic             rti_restore;

    logic [2:0]       ccr;
    logic             pc_load;
    logic [WIDTH-1:0] pc_target;
    logic             flush;
    logic [CW-1:0]    stack_count;
    logic             stack_ovf;
    logic             stack_unf;

    modport slave (
        input  alu_valid, flag_we, carry_in, negative_in, zero_in,
        input  set_c, clr_c, br_valid, br_cond, br_target,
        input  int_save, rti_restore,
        output ccr, pc_load, pc_target, flush, stack_count, stack_ovf, stack_unf
    );

    modport master (
        output alu_valid, flag_we, carry_in, negative_in, zero_in,
        output set_c, clr_c, br_valid, br_cond, br_target,
        output int_save, rti_restore,
        input  ccr, pc_load, pc_target, flush, stack_count, stack_ovf, stack_unf
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Condition-code register, branch resolution with wrong-path shadow, and a
// CCR save stack for interrupt entry / RTI.
module flag_branch_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4,
    parameter int SHADOW      = 2
) (
    input  logic             clk,
    input  logic             reset,
    flag_branch_unit_if.slave bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SW = (SHADOW > 1) ? $clog2(SHADOW) : 1;
    localparam logic [CW-1:0] FULL    = CW'(STACK_DEPTH);
    localparam logic [SW-1:0] SH_LOAD = SW'(SHADOW - 1);

    localparam logic [1:0] BR_JZ  = 2'b00;
    localparam logic [1:0] BR_JN  = 2'b01;
    localparam logic [1:0] BR_JC  = 2'b10;
    localparam logic [1:0] BR_JMP = 2'b11;

    typedef enum logic {S_RUN, S_SHADOW} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sh_cnt_q, sh_cnt_d;
    logic [2:0]       ccr_q, ccr_d;
    logic             pc_load_q, pc_load_d;
    logic [WIDTH-1:0] pc_target_q, pc_target_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [2:0]       stack_q [STACK_DEPTH];

    logic       act, alu_en, setc_en, clrc_en, br_en;
    logic       pop_req, push_req, pop_en, push_en, stk_empty, stk_full;
    logic [IW-1:0] top_idx, push_idx;
    logic       c_alu, n_alu, z_alu, c_sc;
    logic [2:0] ccr_fwd;
    logic       cond_true, taken;

    // Everything on the EX side is squashed while in shadow; the stack ops
    // are interrupt-driven and never wrong-path, so they bypass the gate.
    assign act     = (state_q == S_RUN);
    assign alu_en  = act & bus.alu_valid;
    assign setc_en = act & bus.set_c;
    assign clrc_en = act & bus.clr_c;
    assign br_en   = act & bus.br_valid;

    assign pop_req   = bus.rti_restore;
    assign push_req  = bus.int_save & ~bus.rti_restore;
    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == FULL);
    assign pop_en    = pop_req & ~stk_empty;
    assign push_en   = push_req & ~stk_full;
    assign top_idx   = IW'(cnt_q - CW'(1));
    assign push_idx  = IW'(cnt_q);

    always_comb begin
        c_alu = (alu_en & bus.flag_we[2]) ? bus.carry_in    : ccr_q[2];
        n_alu = (alu_en & bus.flag_we[1]) ? bus.negative_in : ccr_q[1];
        z_alu = (alu_en & bus.flag_we[0]) ? bus.zero_in     : ccr_q[0];
        c_sc  = c_alu;
        if (setc_en & ~clrc_en)      c_sc = 1'b1;
        else if (clrc_en & ~setc_en) c_sc = 1'b0;
        ccr_fwd = pop_en ? stack_q[top_idx] : {c_sc, n_alu, z_alu};
    end

    // Condition sees the forwarded flags so a same-cycle ALU write counts.
    always_comb begin
        cond_true = 1'b0;
        case (bus.br_cond)
            BR_JZ:   cond_true = ccr_fwd[0];
            BR_JN:   cond_true = ccr_fwd[1];
            BR_JC:   cond_true = ccr_fwd[2];
            BR_JMP:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
        taken = br_en & cond_true;
    end

    always_comb begin
        ccr_d = ccr_fwd;
        if (taken && !pop_en) begin
            case (bus.br_cond)
                BR_JZ:   ccr_d[0] = 1'b0;
                BR_JN:   ccr_d[1] = 1'b0;
                BR_JC:   ccr_d[2] = 1'b0;
                default: ccr_d = ccr_fwd;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_cnt_d    = sh_cnt_q;
        pc_load_d   = taken;
        pc_target_d = taken ? bus.br_target : pc_target_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q | (push_req & stk_full);
        unf_d       = unf_q | (pop_req & stk_empty);
        if (pop_en)       cnt_d = cnt_q - CW'(1);
        else if (push_en) cnt_d = cnt_q + CW'(1);
        case (state_q)
            S_RUN: begin
                if (taken) begin
                    state_d  = S_SHADOW;
                    sh_cnt_d = SH_LOAD;
                end
            end
            S_SHADOW: begin
                if (sh_cnt_q == '0) state_d  = S_RUN;
                else                sh_cnt_d = sh_cnt_q - SW'(1);
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            sh_cnt_q    <= '0;
            ccr_q       <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            ccr_q       <= ccr_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Push saves the pre-edge CCR, not the value being written this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else if (push_en) begin
            stack_q[push_idx] <= ccr_q;
        end
    end

    assign bus.ccr         = ccr_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.flush       = pc_load_q;
    assign bus.pc_target   = pc_target_q;
    assign bus.stack_count = cnt_q;
    assign bus.stack_ovf   = ovf_q;
    assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: vector table through a scoreboard
// queue, plus hand sequences for reset, forwarding, shadow and stack limits.
module tb_flag_branch_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    flag_branch_unit_if #(.WIDTH(16), .STACK_DEPTH(4)) bus ();

    flag_branch_unit #(.WIDTH(16), .STACK_DEPTH(4), .SHADOW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        av;
        logic [2:0]  we;
        logic [2:0]  cnz;
        logic        sc, cc, bv;
        logic [1:0]  bc;
        logic [15:0] bt;
        logic        is, rr;
        logic [2:0]  e_ccr;
        logic        e_pl;
        logic [15:0] e_tgt;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  ccr;
        logic        pl;
        logic [15:0] tgt;
        logic [2:0]  cnt;
    } exp_t;

    vec_t tbl [16];
    exp_t exp_q [$];

    function automatic vec_t mk(input logic av, input logic [2:0] we, input logic [2:0] cnz,
                                input logic sc, input logic cc, input logic bv,
                                input logic [1:0] bc, input logic [15:0] bt,
                                input logic is, input logic rr,
                                input logic [2:0] eccr, input logic epl,
                                input logic [15:0] etgt, input logic [2:0] ecnt);
        vec_t v;
        v.av = av; v.we = we; v.cnz = cnz; v.sc = sc; v.cc = cc; v.bv = bv;
        v.bc = bc; v.bt = bt; v.is = is; v.rr = rr;
        v.e_ccr = eccr; v.e_pl = epl; v.e_tgt = etgt; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] we, input logic [2:0] cnz,
                         input logic sc, input logic cc, input logic bv,
                         input logic [1:0] bc, input logic [15:0] bt,
                         input logic is, input logic rr);
        bus.alu_valid   = av;
        bus.flag_we     = we;
        bus.carry_in    = cnz[2];
        bus.negative_in = cnz[1];
        bus.zero_in     = cnz[0];
        bus.set_c       = sc;
        bus.clr_c       = cc;
        bus.br_valid    = bv;
        bus.br_cond     = bc;
        bus.br_target   = bt;
        bus.int_save    = is;
        bus.rti_restore = rr;
    endtask

    task automatic idle();
        drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cols: av we cnz sc cc bv bc bt is rr | ccr pl tgt cnt
        tbl[0]  = mk(1, 3'b111, 3'b011, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 3'b011, 0, 16'h0000, 3'd0);
        tbl[1]  = mk(1, 3'b001, 3'b000, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 3'b010, 0, 16'h0000, 3'd0);
        tbl[2]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 2'b00, 16'h0000, 0, 0, 3'b110, 0, 16'h0000, 3'd0);
        tbl[3]  = mk(0, 3'b000, 3'b000, 1, 1, 0, 2'b00, 16'h0000, 0, 0, 3'b110, 0, 16'h0000, 3'd0);
        tbl[4]  = mk(1, 3'b100, 3'b100, 0, 1, 0, 2'b00, 16'h0000, 0, 0, 3'b010, 0, 16'h0000, 3'd0);
        tbl[5]  = mk(0, 3'b000, 3'b000, 0, 0, 1, 2'b00, 16'h5555, 0, 0, 3'b010, 0, 16'h0000, 3'd0);
        tbl[6]  = mk(1, 3'b100, 3'b100, 0, 0, 1, 2'b10, 16'h2222, 0, 0, 3'b010, 1, 16'h2222, 3'd0);
        tbl[7]  = mk(1, 3'b111, 3'b111, 0, 0, 1, 2'b11, 16'h7777, 0, 0, 3'b010, 0, 16'h0000, 3'd0);
        tbl[8]  = mk(0, 3'b000, 3'b000, 1, 0, 0, 2'b00, 16'h0000, 0, 0, 3'b010, 0, 16'h0000, 3'd0);
        tbl[9]  = mk(0, 3'b000, 3'b000, 0, 0, 1, 2'b01, 16'h00AA, 0, 0, 3'b000, 1, 16'h00AA, 3'd0);
        tbl[10] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0000, 1, 0, 3'b000, 0, 16'h0000, 3'd1);
        tbl[11] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 3'b000, 0, 16'h0000, 3'd1);
        tbl[12] = mk(1, 3'b111, 3'b101, 0, 0, 0, 2'b00, 16'h0000, 0, 0, 3'b101, 0, 16'h0000, 3'd1);
        tbl[13] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0000, 1, 0, 3'b101, 0, 16'h0000, 3'd2);
        tbl[14] = mk(1, 3'b111, 3'b010, 0, 0, 0, 2'b00, 16'h0000, 0, 1, 3'b101, 0, 16'h0000, 3'd1);
        tbl[15] = mk(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0000, 0, 1, 3'b000, 0, 16'h0000, 3'd0);

        idle();
        reset = 1'b0;
        #2;
        chk("rst_ccr", 0, 32'(bus.ccr), 32'h0);
        chk("rst_pl",  0, 32'(bus.pc_load), 32'h0);
        chk("rst_cnt", 0, 32'(bus.stack_count), 32'h0);
        chk("rst_ovf", 0, 32'(bus.stack_ovf), 32'h0);
        chk("rst_unf", 0, 32'(bus.stack_unf), 32'h0);
        #10 reset = 1'b1;
        step();

        // Reset landing while a redirect is being presented
        drive(1, 3'b111, 3'b111, 0, 0, 0, 2'b00, 16'h0, 0, 0); step();
        chk("pre_ccr", 0, 32'(bus.ccr), 32'h7);
        drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 0); step();
        chk("pre_cnt", 0, 32'(bus.stack_count), 32'h1);
        drive(0, 3'b000, 3'b000, 0, 0, 1, 2'b11, 16'h0040, 0, 0); step();
        idle();
        chk("jmp_pl",  0, 32'(bus.pc_load), 32'h1);
        chk("jmp_fl",  0, 32'(bus.flush), 32'h1);
        chk("jmp_tgt", 0, 32'(bus.pc_target), 32'h0040);
        chk("jmp_ccr", 0, 32'(bus.ccr), 32'h7);
        #2 reset = 1'b0;
        #1;
        chk("arst_pl",  0, 32'(bus.pc_load), 32'h0);
        chk("arst_fl",  0, 32'(bus.flush), 32'h0);
        chk("arst_ccr", 0, 32'(bus.ccr), 32'h0);
        chk("arst_cnt", 0, 32'(bus.stack_count), 32'h0);
        chk("arst_tgt", 0, 32'(bus.pc_target), 32'h0);
        #3 reset = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            exp_t e;
            drive(tbl[i].av, tbl[i].we, tbl[i].cnz, tbl[i].sc, tbl[i].cc, tbl[i].bv,
                  tbl[i].bc, tbl[i].bt, tbl[i].is, tbl[i].rr);
            e.idx = i; e.ccr = tbl[i].e_ccr; e.pl = tbl[i].e_pl;
            e.tgt = tbl[i].e_tgt; e.cnt = tbl[i].e_cnt;
            exp_q.push_back(e);
            step();
            e = exp_q.pop_front();
            chk("v_ccr", e.idx, 32'(bus.ccr), 32'(e.ccr));
            chk("v_pl",  e.idx, 32'(bus.pc_load), 32'(e.pl));
            chk("v_fl",  e.idx, 32'(bus.flush), 32'(e.pl));
            chk("v_cnt", e.idx, 32'(bus.stack_count), 32'(e.cnt));
            if (e.pl) chk("v_tgt", e.idx, 32'(bus.pc_target), 32'(e.tgt));
        end
        idle();

        // Same-cycle ALU Z write forwarded into JZ
        drive(1, 3'b001, 3'b001, 0, 0, 1, 2'b00, 16'h1234, 0, 0); step();
        idle();
        chk("fwd_pl",  0, 32'(bus.pc_load), 32'h1);
        chk("fwd_fl",  0, 32'(bus.flush), 32'h1);
        chk("fwd_tgt", 0, 32'(bus.pc_target), 32'h1234);
        chk("fwd_ccr", 0, 32'(bus.ccr), 32'h0);
        step();
        chk("fwd_pl1", 0, 32'(bus.pc_load), 32'h0);
        step();

        // Two shadow cycles after JMP swallow JC+ALU; the third is honoured
        drive(0, 3'b000, 3'b000, 0, 0, 1, 2'b11, 16'h0100, 0, 0); step();
        chk("sh_pl0", 0, 32'(bus.pc_load), 32'h1);
        for (int k = 1; k <= 2; k++) begin
            drive(1, 3'b110, 3'b110, 0, 0, 1, 2'b10, 16'h0300, 0, 0); step();
            chk("sh_pl",  k, 32'(bus.pc_load), 32'h0);
            chk("sh_ccr", k, 32'(bus.ccr), 32'h0);
        end
        drive(1, 3'b110, 3'b110, 0, 0, 1, 2'b10, 16'h0300, 0, 0); step();
        idle();
        chk("sh_pl3",  0, 32'(bus.pc_load), 32'h1);
        chk("sh_tgt3", 0, 32'(bus.pc_target), 32'h0300);
        chk("sh_ccr3", 0, 32'(bus.ccr), 32'h2);
        step(); step();

        // Overflow, pop-wins on simultaneous save/restore, then underflow
        for (int k = 1; k <= 5; k++) begin
            drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 0); step();
            chk("ovf_cnt", k, 32'(bus.stack_count), 32'((k > 4) ? 4 : k));
            chk("ovf_flg", k, 32'(bus.stack_ovf), 32'((k > 4) ? 1 : 0));
        end
        drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 1, 1); step();
        chk("both_cnt", 0, 32'(bus.stack_count), 32'h3);
        chk("both_ccr", 0, 32'(bus.ccr), 32'h2);
        chk("both_ovf", 0, 32'(bus.stack_ovf), 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 0, 1); step();
        end
        chk("pop_cnt", 0, 32'(bus.stack_count), 32'h0);
        chk("pop_unf", 0, 32'(bus.stack_unf), 32'h0);
        drive(0, 3'b000, 3'b000, 0, 0, 0, 2'b00, 16'h0, 0, 1); step();
        idle();
        chk("unf_flg", 0, 32'(bus.stack_unf), 32'h1);
        chk("unf_cnt", 0, 32'(bus.stack_count), 32'h0);
        chk("unf_ccr", 0, 32'(bus.ccr), 32'h2);
        step();
        chk("unf_sticky", 0, 32'(bus.stack_unf), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
